inst_encoder: RTL
=================

// Module: inst_encoder
// PURPOSE
// - Inverse of the core's immediate decode: packs opcode/register/funct fields and a 32-bit immediate into an RV32I instruction word.
// - Used by the on-chip program loader and self-test sequencer to build instructions before writing them to IMEM.
// - Valid/ready on both sides, range/alignment check on the immediate, 2-entry output buffer, and accept/error counters.
// PARAMETERS
// - CNT_W    16            width of the accepted-instruction counter
// - ERR_W    8             width of the saturating error counter
// - NOP_INST 32'h00000013  word emitted in place of an illegal encoding (addi x0,x0,0)
// PORTS
// - clk          in   1      rising-edge clock; the only clock in the block
// - rst_n        in   1      asynchronous, active-low reset
// - in_valid     in   1      request valid
// - in_ready     out  1      block can accept a request this cycle
// - in_imm_sel   in   3      format: 0=I 1=S 2=B 3=U 4=J 5=R; 6 and 7 are illegal
// - in_opcode    in   7      opcode field [6:0]
// - in_rd        in   5      rd field (I/U/J/R only)
// - in_rs1       in   5      rs1 field (I/S/B/R only)
// - in_rs2       in   5      rs2 field (S/B/R only)
// - in_funct3    in   3      funct3 field (I/S/B/R only)
// - in_funct7    in   7      funct7 field (R only)
// - in_imm       in   32     byte-offset immediate, full 32-bit value (ignored for R)
// - out_valid    out  1      out_inst/out_err hold a result
// - out_ready    in   1      consumer takes the result when out_valid && out_ready
// - out_inst     out  32     encoded instruction
// - out_err      out  1      request was illegal; out_inst = NOP_INST
// - cnt_clr      in   1      synchronous clear of both counters
// - enc_count    out  CNT_W  number of accepted requests; wraps
// - err_count    out  ERR_W  number of illegal requests; saturates at all-ones
// BEHAVIOUR
// - Reset (rst_n=0, asynchronous): buffer empty; out_valid=0, out_inst=0, out_err=0, enc_count=0, err_count=0; in_ready=1 on the first edge after release.
// - Request is accepted on an edge where in_valid && in_ready. Unused fields for the selected format are don't-care.
// - Packing:
//   - I: imm[11:0], rs1, f3, rd, op
//   - S: imm[11:5], rs2, rs1, f3, imm[4:0], op
//   - B: imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op
//   - U: imm[31:12], rd, op
//   - J: imm[20], imm[10:1], imm[11], imm[19:12], rd, op
//   - R: f7, rs2, rs1, f3, rd, op
// - Legality (any violation sets out_err=1 and out_inst=NOP_INST):
//   - I/S: imm[31:11] are all equal (signed 12-bit range)
//   - B: imm[31:12] are all equal and imm[0]=0
//   - J: imm[31:20] are all equal and imm[0]=0
//   - U: imm[11:0]=0
//   - imm_sel 6 or 7: always illegal
// - Buffer: 2-entry FIFO, count 0..2. in_ready = (count<2), driven from a register; it does not depend combinationally on out_ready.
// - Latency: a request accepted at edge N, with the buffer empty, is presented with out_valid=1 after edge N. Output order equals acceptance order.
// - Push and pop on the same edge: count unchanged. At count=2, in_ready=0, so no push occurs even if the same edge pops.
// - out_inst/out_err are stable while out_valid && !out_ready (no change until the handshake).
// - enc_count increments by 1 per accepted request, wrapping from all-ones to 0.
// - err_count increments by 1 per accepted illegal request and saturates at all-ones.
// - cnt_clr has priority over a same-cycle increment: both counters read 0 after the edge.
// - Reset asserted mid-operation discards buffered results and clears the counters immediately.
// TESTING
// 1. I-type: op=0x13 rd=1 rs1=0 f3=0 imm=5 -> out_inst=0x00500093, err=0, one cycle after accept.
// 2. S-type: op=0x23 rs1=1 rs2=2 f3=2 imm=8 -> 0x0020A423. B-type: op=0x63 rs1=0 rs2=0 f3=0 imm=-4 -> 0xFE000EE3.
// 3. U-type: op=0x37 rd=5 imm=0x12345000 -> 0x123452B7. J-type: op=0x6F rd=1 imm=8 -> 0x008000EF.
// 4. Illegal requests: I with imm=2048, B with imm=3, U with imm=0x12345001, imm_sel=7 -> each gives 0x00000013 with err=1; err_count=4.
// 5. Hold out_ready=0, drive in_valid=1 continuously -> 2 accepts, then in_ready=0. Release out_ready -> results drain in order with no loss or duplicate; enc_count=2.
// 6. Assert rst_n low with 2 results buffered -> out_valid=0 immediately (asynchronously). Assert cnt_clr together with an accept -> enc_count=0.

Source files
------------

// File: rtl/inst_encoder.sv
`default_nettype none
// ============================================================================
// Module   : inst_encoder
// Purpose  : Packs opcode/register/funct fields and a 32-bit byte-offset
//            immediate into an RV32I instruction word. Illegal immediates
//            (out of range or misaligned) and illegal formats produce
//            NOP_INST with out_err set. Results pass through a 2-entry
//            FIFO with valid/ready on both sides. Accepted requests and
//            illegal requests are counted.
// Ports    : clk, rst_n           clock, asynchronous active-low reset
//            in_valid/in_ready   request handshake
//            in_imm_sel          format 0=I 1=S 2=B 3=U 4=J 5=R (6,7 illegal)
//            in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm
//            out_valid/out_ready result handshake
//            out_inst, out_err   encoded word and illegal flag
//            cnt_clr             synchronous clear of both counters
//            enc_count           accepted requests (wrapping)
//            err_count           illegal requests (saturating)
// Revision : 1.0 - initial release
// ============================================================================
module inst_encoder #(
  parameter int          CNT_W    = 16,
  parameter int          ERR_W    = 8,
  parameter logic [31:0] NOP_INST = 32'h00000013
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_imm_sel,
  input  logic [6:0]       in_opcode,
  input  logic [4:0]       in_rd,
  input  logic [4:0]       in_rs1,
  input  logic [4:0]       in_rs2,
  input  logic [2:0]       in_funct3,
  input  logic [6:0]       in_funct7,
  input  logic [31:0]      in_imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_inst,
  output logic             out_err,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] enc_count,
  output logic [ERR_W-1:0] err_count
);

  localparam logic [2:0] c_SEL_I = 3'd0;
  localparam logic [2:0] c_SEL_S = 3'd1;
  localparam logic [2:0] c_SEL_B = 3'd2;
  localparam logic [2:0] c_SEL_U = 3'd3;
  localparam logic [2:0] c_SEL_J = 3'd4;
  localparam logic [2:0] c_SEL_R = 3'd5;

  // ---------------------------------------------------------------------------
  // Field packing and legality check
  // ---------------------------------------------------------------------------
  logic [31:0] w_raw_inst;
  logic        w_legal;
  logic [31:0] w_enc_inst;
  logic        w_enc_err;

  always_comb begin
    w_raw_inst = 32'd0;
    w_legal    = 1'b0;
    case (in_imm_sel)
      c_SEL_I: begin
        w_raw_inst = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
        w_legal    = (&in_imm[31:11]) | ~(|in_imm[31:11]);
      end
      c_SEL_S: begin
        w_raw_inst = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
        w_legal    = (&in_imm[31:11]) | ~(|in_imm[31:11]);
      end
      c_SEL_B: begin
        w_raw_inst = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                      in_imm[4:1], in_imm[11], in_opcode};
        w_legal    = ((&in_imm[31:12]) | ~(|in_imm[31:12])) & ~in_imm[0];
      end
      c_SEL_U: begin
        w_raw_inst = {in_imm[31:12], in_rd, in_opcode};
        w_legal    = ~(|in_imm[11:0]);
      end
      c_SEL_J: begin
        w_raw_inst = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12],
                      in_rd, in_opcode};
        w_legal    = ((&in_imm[31:20]) | ~(|in_imm[31:20])) & ~in_imm[0];
      end
      c_SEL_R: begin
        w_raw_inst = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
        w_legal    = 1'b1;
      end
      default: begin
        w_raw_inst = 32'd0;
        w_legal    = 1'b0;
      end
    endcase
    w_enc_inst = w_legal ? w_raw_inst : NOP_INST;
    w_enc_err  = ~w_legal;
  end

  // ---------------------------------------------------------------------------
  // 2-entry output FIFO. Entry 0 is always the head and drives the outputs
  // directly, so the presented result is a plain register.
  // ---------------------------------------------------------------------------
  logic [1:0]  r_count;
  logic        r_in_ready;
  logic        r_out_valid;
  logic [31:0] r_inst0;
  logic        r_err0;
  logic [31:0] r_inst1;
  logic        r_err1;
  logic [CNT_W-1:0] r_enc_count;
  logic [ERR_W-1:0] r_err_count;

  logic       w_push;
  logic       w_pop;
  logic [1:0] w_count_nxt;

  assign w_push = in_valid & r_in_ready;
  assign w_pop  = r_out_valid & out_ready;

  always_comb begin
    w_count_nxt = r_count;
    if (w_push && !w_pop) begin
      w_count_nxt = r_count + 2'd1;
    end else if (!w_push && w_pop) begin
      w_count_nxt = r_count - 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count     <= 2'd0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_inst0     <= 32'd0;
      r_err0      <= 1'b0;
      r_inst1     <= 32'd0;
      r_err1      <= 1'b0;
    end else begin
      r_count     <= w_count_nxt;
      // Ready and valid are precomputed from the next occupancy so neither
      // depends combinationally on the opposite handshake.
      r_in_ready  <= (w_count_nxt != 2'd2);
      r_out_valid <= (w_count_nxt != 2'd0);
      if (w_push && w_pop) begin
        // Only reachable with one entry held: new word becomes the head.
        r_inst0 <= w_enc_inst;
        r_err0  <= w_enc_err;
      end else if (w_push) begin
        if (r_count == 2'd0) begin
          r_inst0 <= w_enc_inst;
          r_err0  <= w_enc_err;
        end else begin
          r_inst1 <= w_enc_inst;
          r_err1  <= w_enc_err;
        end
      end else if (w_pop && (r_count == 2'd2)) begin
        r_inst0 <= r_inst1;
        r_err0  <= r_err1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Counters; a clear wins over a same-cycle increment.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_enc_count <= '0;
      r_err_count <= '0;
    end else if (cnt_clr) begin
      r_enc_count <= '0;
      r_err_count <= '0;
    end else if (w_push) begin
      r_enc_count <= r_enc_count + CNT_W'(1);
      if (w_enc_err && (r_err_count != {ERR_W{1'b1}})) begin
        r_err_count <= r_err_count + ERR_W'(1);
      end
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_inst  = r_inst0;
  assign out_err   = r_err0;
  assign enc_count = r_enc_count;
  assign err_count = r_err_count;

endmodule
`default_nettype wire
